// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encoding and
// a constant log2 helper for sizing index ports.
package rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Ceiling log2 usable in parameter expressions.
    function automatic int clog2_int(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter_bitscan.sv
// Lowest-set-bit finder: returns a one-hot copy of the lowest set bit of vec
// and a flag telling whether any bit was set at all.
module bitscan #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] vec,
    output logic [WIDTH-1:0] onehot,
    output logic             found
);

    // Two's-complement trick isolates the lowest set bit in one carry chain.
    assign onehot = vec & (~vec + WIDTH'(1));
    assign found  = |vec;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with grant hold and optional hold-limit preemption.
// All outputs are registered; the priority pointer rotates past each winner.
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int IDX_W    = 4,
    parameter int MAX_HOLD = 0,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] base_nxt;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [WIDTH-1:0] grant_nxt;
    logic             load;
    logic             preempt;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] masked;
    logic [WIDTH-1:0] pick_masked;
    logic [WIDTH-1:0] pick_req;
    logic [WIDTH-1:0] pick;
    logic             masked_any;
    logic             cand_any;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] result;
        result = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                result = result | IDX_W'(i);
            end
        end
        return result;
    endfunction

    // Preemption hands off only when someone else is waiting, so a lone holder keeps the grant.
    assign preempt = (MAX_HOLD != 0) && (state == ST_BUSY) && ((req & grant) != '0)
                     && (hold_cnt == CNT_W'(MAX_HOLD - 1)) && ((req & ~grant) != '0);

    assign cand   = preempt ? (req & ~grant) : req;
    assign masked = cand & ~(base - WIDTH'(1));

    bitscan #(.WIDTH(WIDTH)) u_scan_masked (
        .vec    (masked),
        .onehot (pick_masked),
        .found  (masked_any)
    );

    bitscan #(.WIDTH(WIDTH)) u_scan_req (
        .vec    (cand),
        .onehot (pick_req),
        .found  (cand_any)
    );

    assign pick = masked_any ? pick_masked : pick_req;

    // Next-state logic; any new grant also rotates base and restarts the hold counter.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        base_nxt  = base;
        cnt_nxt   = hold_cnt;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cand_any) begin
                    load      = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if ((req & grant) == '0) begin
                    if (cand_any) begin
                        load = 1'b1;
                    end else begin
                        grant_nxt = '0;
                        state_nxt = ST_IDLE;
                    end
                end else if (preempt) begin
                    load = 1'b1;
                end else if (hold_cnt != {CNT_W{1'b1}}) begin
                    cnt_nxt = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = '0;
            end
        endcase
        if (load) begin
            grant_nxt = pick;
            base_nxt  = {pick[WIDTH-2:0], pick[WIDTH-1]};
            cnt_nxt   = '0;
        end
    end

    // State and output registers; reset clears outputs and returns priority to requester 0.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state       <= ST_IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            base        <= WIDTH'(1);
            hold_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            grant_valid <= |grant_nxt;
            grant_idx   <= onehot_to_idx(grant_nxt);
            base        <= base_nxt;
            hold_cnt    <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: two instances (no hold limit, and hold limit 4) checked
// every cycle against an index-based round-robin model, plus directed literal checks.
module tb_rr_arbiter;

    localparam int W = 16;

    logic         clk  = 1'b0;
    logic         arst = 1'b0;
    logic [W-1:0] req  = '0;
    logic [W-1:0] grant0;
    logic [W-1:0] grant1;
    logic         valid0;
    logic         valid1;
    logic [3:0]   idx0;
    logic [3:0]   idx1;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    rr_arbiter #(.WIDTH(W), .IDX_W(4), .MAX_HOLD(0), .CNT_W(8)) u0 (
        .clk         (clk),
        .arst        (arst),
        .req         (req),
        .grant       (grant0),
        .grant_valid (valid0),
        .grant_idx   (idx0)
    );

    rr_arbiter #(.WIDTH(W), .IDX_W(4), .MAX_HOLD(4), .CNT_W(8)) u1 (
        .clk         (clk),
        .arst        (arst),
        .req         (req),
        .grant       (grant1),
        .grant_valid (valid1),
        .grant_idx   (idx1)
    );

    // Reference model: grant and priority pointer kept as plain integer indices.
    int           mg[2];
    int           mb[2];
    int           mc[2];
    int           mhold[2] = '{0, 4};
    logic [W-1:0] prevReq = '0;

    function automatic int pickFrom(input logic [W-1:0] r, input int b);
        for (int k = 0; k < W; k++) begin
            if (r[(b + k) % W]) return (b + k) % W;
        end
        return -1;
    endfunction

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            mg[m] = -1;
            mb[m] = 0;
            mc[m] = 0;
        end
        prevReq = '0;
    endtask

    task automatic modelStep(input int m, input logic [W-1:0] r);
        int           n;
        logic [W-1:0] others;
        n = -1;
        if (mg[m] < 0) begin
            if (r != '0) n = pickFrom(r, mb[m]);
        end else begin
            others = r;
            others[mg[m]] = 1'b0;
            if (!r[mg[m]]) begin
                if (r != '0) n = pickFrom(r, mb[m]);
                else mg[m] = -1;
            end else if (mhold[m] != 0 && mc[m] == mhold[m] - 1 && others != '0) begin
                n = pickFrom(others, mb[m]);
            end else if (mc[m] < 255) begin
                mc[m] = mc[m] + 1;
            end
        end
        if (n >= 0) begin
            mg[m] = n;
            mb[m] = (n + 1) % W;
            mc[m] = 0;
        end
    endtask

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            modelReset();
        end else begin
            modelStep(0, req);
            modelStep(1, req);
            prevReq = req;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Per-cycle compare of both instances against the model, plus invariants on DUT grants.
    logic [W-1:0] lastG[2] = '{default: '0};
    int           dw[2][W];

    always @(negedge clk) begin
        if (started) begin
            for (int m = 0; m < 2; m++) begin
                logic [W-1:0] g;
                logic [W-1:0] b;
                logic         v;
                logic [3:0]   ix;
                logic [31:0]  expG;
                int           maxw;
                g  = (m == 0) ? grant0 : grant1;
                v  = (m == 0) ? valid0 : valid1;
                ix = (m == 0) ? idx0 : idx1;
                b  = (m == 0) ? u0.base : u1.base;
                expG = (mg[m] < 0) ? 32'h0 : (32'h1 << mg[m]);
                checkOutput($sformatf("grant%0d", m), 32'(g), expG);
                checkOutput($sformatf("valid%0d", m), 32'(v), (mg[m] < 0) ? 32'h0 : 32'h1);
                checkOutput($sformatf("idx%0d", m), 32'(ix), (mg[m] < 0) ? 32'h0 : 32'(mg[m]));
                checkOutput($sformatf("base%0d", m), 32'(b), 32'h1 << mb[m]);
                checkOutput($sformatf("onehot%0d", m), 32'($countones(g) <= 1), 32'h1);
                checkOutput($sformatf("subset%0d", m), 32'(g & ~prevReq), 32'h0);
                maxw = 0;
                for (int j = 0; j < W; j++) begin
                    if (g != '0 && g != lastG[m] && prevReq[j] && !g[j]) dw[m][j]++;
                    else if (!prevReq[j] || g[j]) dw[m][j] = 0;
                    if (dw[m][j] > maxw) maxw = dw[m][j];
                end
                lastG[m] = g;
                checkOutput($sformatf("fairwait%0d", m), 32'(maxw <= W), 32'h1);
            end
        end
    end

    task automatic applyStimulus(input logic [W-1:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] fairReq[4] = '{16'h0013, 16'h0012, 16'h0011, 16'h0003};
    logic [W-1:0] fairG[4]   = '{16'h0001, 16'h0002, 16'h0010, 16'h0001};
    int           fairI[4]   = '{0, 1, 4, 0};

    initial begin
        logic [W-1:0] r;
        #1 arst = 1'b1;
        started = 1'b1;
        repeat (3) @(posedge clk);
        #1 arst = 1'b0;
        checkOutput("reset grant0", 32'(grant0), 32'h0);
        checkOutput("reset valid0", 32'(valid0), 32'h0);
        checkOutput("reset base0", 32'(u0.base), 32'h1);

        repeat (10) begin
            applyStimulus('0);
            checkOutput("idle grant0", 32'(grant0), 32'h0);
            checkOutput("idle valid1", 32'(valid1), 32'h0);
            checkOutput("idle idx0", 32'(idx0), 32'h0);
        end

        for (int i = 0; i < 4; i++) begin
            applyStimulus(fairReq[i]);
            checkOutput("fair grant0", 32'(grant0), 32'(fairG[i]));
            checkOutput("fair idx0", 32'(idx0), 32'(fairI[i]));
            checkOutput("fair grant1", 32'(grant1), 32'(fairG[i]));
        end

        applyStimulus(16'h8000);
        checkOutput("wrap hold grant0", 32'(grant0), 32'h8000);
        checkOutput("wrap hold idx0", 32'(idx0), 32'd15);
        applyStimulus(16'h8000);
        checkOutput("wrap still grant0", 32'(grant0), 32'h8000);
        applyStimulus(16'h0005);
        checkOutput("wrap grant0", 32'(grant0), 32'h0001);
        checkOutput("wrap base0", 32'(u0.base), 32'h0002);

        applyStimulus('0);
        checkOutput("pre idle grant1", 32'(grant1), 32'h0);
        applyStimulus(16'h0008);
        checkOutput("pre load grant1", 32'(grant1), 32'h0008);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(16'h0088);
            checkOutput("pre held grant1", 32'(grant1), 32'h0008);
        end
        applyStimulus(16'h0088);
        checkOutput("preempt grant1", 32'(grant1), 32'h0080);
        checkOutput("nolimit grant0", 32'(grant0), 32'h0008);
        repeat (10) begin
            applyStimulus(16'h0008);
            checkOutput("lone grant1", 32'(grant1), 32'h0008);
        end

        applyStimulus(16'h0100);
        checkOutput("busy grant0", 32'(grant0), 32'h0100);
        #2 arst = 1'b1;
        #1;
        checkOutput("arst grant0", 32'(grant0), 32'h0);
        checkOutput("arst valid0", 32'(valid0), 32'h0);
        checkOutput("arst idx0", 32'(idx0), 32'h0);
        checkOutput("arst grant1", 32'(grant1), 32'h0);
        @(posedge clk);
        #1 arst = 1'b0;
        applyStimulus(16'h0101);
        checkOutput("post arst grant0", 32'(grant0), 32'h0001);
        checkOutput("post arst grant1", 32'(grant1), 32'h0001);

        r = req;
        for (int c = 0; c < 10000; c++) begin
            int sel;
            sel = int'($urandom_range(0, 15));
            if (sel == 0) r = '0;
            else if (sel < 4) r = W'($urandom & $urandom);
            else r[$urandom_range(0, W - 1)] = ~r[$urandom_range(0, W - 1)];
            if (mg[0] >= 0 && $urandom_range(0, 3) == 0) r[mg[0]] = 1'b0;
            if (mg[1] >= 0 && $urandom_range(0, 5) == 0) r[mg[1]] = 1'b0;
            applyStimulus(r);
        end

        applyStimulus('0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
